// File: rtl/pattern_player_pkg.sv
// Shared types and default constants for the pattern player.
// Optional looping playback is enabled with the macro PATTERN_PLAYER_LOOP_EN.
package pattern_player_pkg;

    localparam int unsigned DEF_NUM_STEPS = 16;
    localparam int unsigned DEF_PAT_W     = 4;
    localparam int unsigned DEF_DWELL_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One step-table entry at the default widths.
    typedef struct packed {
        logic [DEF_PAT_W-1:0]   pat;
        logic [DEF_DWELL_W-1:0] dwell;
    } step_t;

endpackage

// File: rtl/pattern_player_table.sv
// Step table: register array, one synchronous write port, one asynchronous
// read port, cleared to all zeros by reset.
module pattern_player_table
    import pattern_player_pkg::*;
#(
    parameter int unsigned NUM_STEPS = DEF_NUM_STEPS,
    parameter int unsigned PAT_W     = DEF_PAT_W,
    parameter int unsigned DWELL_W   = DEF_DWELL_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  logic [$clog2(NUM_STEPS)-1:0] wr_addr_i,
    input  logic [PAT_W-1:0]             wr_pat_i,
    input  logic [DWELL_W-1:0]           wr_dwell_i,
    input  logic [$clog2(NUM_STEPS)-1:0] rd_addr_i,
    output logic [PAT_W-1:0]             rd_pat_o,
    output logic [DWELL_W-1:0]           rd_dwell_o
);

    localparam int unsigned AW = $clog2(NUM_STEPS);

    logic [PAT_W-1:0]   pat_q   [NUM_STEPS];
    logic [DWELL_W-1:0] dwell_q [NUM_STEPS];

    // Clear on reset; otherwise write the addressed entry when strobed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                pat_q[i]   <= '0;
                dwell_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                if (wr_en_i && (wr_addr_i == AW'(i))) begin
                    pat_q[i]   <= wr_pat_i;
                    dwell_q[i] <= wr_dwell_i;
                end
            end
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        rd_pat_o   = pat_q[rd_addr_i];
        rd_dwell_o = dwell_q[rd_addr_i];
    end

endmodule

// File: rtl/pattern_player.sv
// Pattern player: steps through a programmable table, holding each pattern
// for dwell+1 cycles, then pulses done. Defining PATTERN_PLAYER_LOOP_EN adds
// a loop input that makes playback wrap to step 0 until aborted.
module pattern_player
    import pattern_player_pkg::*;
#(
    parameter int unsigned NUM_STEPS = DEF_NUM_STEPS,
    parameter int unsigned PAT_W     = DEF_PAT_W,
    parameter int unsigned DWELL_W   = DEF_DWELL_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
    input  logic [PAT_W-1:0]             wr_pat,
    input  logic [DWELL_W-1:0]           wr_dwell,
    input  logic [$clog2(NUM_STEPS)-1:0] last_step,
    input  logic                         start,
    input  logic                         abort,
`ifdef PATTERN_PLAYER_LOOP_EN
    input  logic                         loop,
`endif
    output logic [PAT_W-1:0]             pat_out,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned AW = $clog2(NUM_STEPS);
    localparam logic [AW-1:0] LAST_MAX = AW'(NUM_STEPS - 1);

    state_t               state_q;
    logic [PAT_W-1:0]     pat_q;
    logic [AW-1:0]        step_q;
    logic                 busy_q;
    logic                 done_q;
    logic [DWELL_W-1:0]   cnt_q;
    logic [AW-1:0]        last_q;
    logic                 loop_q;

    logic [AW-1:0]        rd_addr_d;
    logic [AW-1:0]        last_eff_d;
    logic                 loop_sel_d;
    logic [PAT_W-1:0]     rd_pat;
    logic [DWELL_W-1:0]   rd_dwell;
    logic                 tbl_wr_en;

`ifdef PATTERN_PLAYER_LOOP_EN
    assign loop_sel_d = loop;
`else
    assign loop_sel_d = 1'b0;
`endif

    // Clamp only exists when the index width can encode out-of-range steps.
    if (NUM_STEPS == (1 << AW)) begin : g_no_clamp
        assign last_eff_d = last_step;
    end else begin : g_clamp
        assign last_eff_d = (last_step > LAST_MAX) ? LAST_MAX : last_step;
    end

    // Table writes are dropped while playback is in progress.
    assign tbl_wr_en = wr_en && !busy_q;

    // The single read port always points at the entry loaded on the next
    // transition: entry 0 from IDLE or after the final step (wrap), else the
    // following step.
    always_comb begin
        rd_addr_d = '0;
        if ((state_q == ST_PLAY) && (step_q != last_q)) begin
            rd_addr_d = step_q + 1'b1;
        end
    end

    pattern_player_table #(
        .NUM_STEPS (NUM_STEPS),
        .PAT_W     (PAT_W),
        .DWELL_W   (DWELL_W)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (tbl_wr_en),
        .wr_addr_i  (wr_addr),
        .wr_pat_i   (wr_pat),
        .wr_dwell_i (wr_dwell),
        .rd_addr_i  (rd_addr_d),
        .rd_pat_o   (rd_pat),
        .rd_dwell_o (rd_dwell)
    );

    // Playback FSM with registered outputs; abort overrides everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_PLAY;
                        pat_q   <= rd_pat;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        cnt_q   <= rd_dwell;
                        last_q  <= last_eff_d;
                        loop_q  <= loop_sel_d;
                    end
                end
                ST_PLAY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if ((step_q != last_q) || loop_q) begin
                        step_q <= rd_addr_d;
                        pat_q  <= rd_pat;
                        cnt_q  <= rd_dwell;
                    end else begin
                        state_q <= ST_DONE;
                        pat_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pat_out  = pat_q;
    assign step_idx = step_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player: a reference table model produces the
// expected per-cycle outputs, queued at start and popped as the DUT plays.
module tb_pattern_player;
    import pattern_player_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_pat;
    logic [15:0] wr_dwell;
    logic [3:0]  last_step;
    logic        start;
    logic        abort;
`ifdef PATTERN_PLAYER_LOOP_EN
    logic        loop;
`endif
    logic [3:0]  pat_out;
    logic [3:0]  step_idx;
    logic        busy;
    logic        done;

    typedef struct {
        logic [3:0] pat;
        logic [3:0] step;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t  sb[$];
    step_t model [16];
    int    n_cmp = 0;
    int    n_err = 0;

    pattern_player #(
        .NUM_STEPS (16),
        .PAT_W     (4),
        .DWELL_W   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_pat    (wr_pat),
        .wr_dwell  (wr_dwell),
        .last_step (last_step),
        .start     (start),
        .abort     (abort),
`ifdef PATTERN_PLAYER_LOOP_EN
        .loop      (loop),
`endif
        .pat_out   (pat_out),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".pat"},  32'(pat_out), 32'h0);
        check({tag, ".busy"}, 32'(busy),    32'h0);
        check({tag, ".done"}, 32'(done),    32'h0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            model[i].pat   = '0;
            model[i].dwell = '0;
        end
    endtask

    // Write one entry while the player is idle; the model follows.
    task automatic wr(input int a, input int p, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(a); wr_pat = 4'(p); wr_dwell = 16'(d);
        @(negedge clk);
        wr_en = 1'b0;
        model[a].pat   = 4'(p);
        model[a].dwell = 16'(d);
    endtask

    // One playback run. start_hold: extra cycles start stays high.
    // abort_at / rst_at: sample index at which abort / reset is applied (-1 none).
    // wr_at: -1 writes entry 0 = 0x9 together with start, -2 none, >=0 during play.
    task automatic play(input int last_in, input int start_hold, input int abort_at,
                        input int wr_at, input int rst_at);
        int   eff;
        int   idx;
        bit   off;
        exp_t e;
        eff = (last_in > 15) ? 15 : last_in;
        sb.delete();
        for (int i = 0; i <= eff; i++) begin
            for (int c = 0; c <= int'(model[i].dwell); c++) begin
                e.pat = model[i].pat; e.step = 4'(i); e.busy = 1'b1; e.done = 1'b0;
                sb.push_back(e);
            end
        end
        e.pat = '0; e.step = '0; e.busy = 1'b0; e.done = 1'b1;
        sb.push_back(e);
        e.done = 1'b0;
        sb.push_back(e);
        sb.push_back(e);

        @(negedge clk);
        last_step = 4'(last_in);  // 4-bit port: 31 arrives as 15
        start = 1'b1;
        if (wr_at == -1) begin
            wr_en = 1'b1; wr_addr = '0; wr_pat = 4'h9; wr_dwell = '0;
        end
        idx = 0;
        off = 1'b0;
        while (sb.size() > 0) begin
            @(negedge clk);
            wr_en = 1'b0;
            abort = 1'b0;
            if (idx >= start_hold) start = 1'b0;
            if (idx == 0) last_step = '0;  // must not affect the captured value
            e = sb.pop_front();
            if (off) begin
                e.pat = '0; e.step = '0; e.busy = 1'b0; e.done = 1'b0;
            end
            check($sformatf("pat[%0d]", idx),  32'(pat_out), 32'(e.pat));
            check($sformatf("busy[%0d]", idx), 32'(busy),    32'(e.busy));
            check($sformatf("done[%0d]", idx), 32'(done),    32'(e.done));
            if (e.busy) check($sformatf("step[%0d]", idx), 32'(step_idx), 32'(e.step));
            if (idx == abort_at) begin
                abort = 1'b1;
                off = 1'b1;
            end
            if (idx == wr_at) begin
                wr_en = 1'b1; wr_addr = '0; wr_pat = 4'h9; wr_dwell = '0;
            end
            if (idx == rst_at) begin
                #3 reset = 1'b1;
                #1;
                check("rst.pat",  32'(pat_out),  32'h0);
                check("rst.step", 32'(step_idx), 32'h0);
                check("rst.busy", 32'(busy),     32'h0);
                check("rst.done", 32'(done),     32'h0);
                off = 1'b1;
                clear_model();
                @(negedge clk);
                reset = 1'b0;
            end
            idx++;
        end
        if (wr_at == -1) begin
            model[0].pat   = 4'h9;
            model[0].dwell = '0;
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_pat = '0; wr_dwell = '0;
        last_step = '0; start = 1'b0; abort = 1'b0;
`ifdef PATTERN_PLAYER_LOOP_EN
        loop = 1'b0;
`endif
        clear_model();
        #1;
        check("reset.step", 32'(step_idx), 32'h0);
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic three-step program.
        wr(0, 4'h1, 1);
        wr(1, 4'h6, 0);
        wr(2, 4'hF, 2);
        play(2, 0, -1, -2, -1);

        // start held during PLAY is ignored; abort during step 1.
        play(2, 2, 2, -2, -1);

        // Write during playback is dropped; replay shows the old entry 0.
        play(2, 0, -1, 2, -1);
        play(2, 0, -1, -2, -1);

        // Same-cycle write and start plays pre-write entry 0, then the new one.
        play(2, 0, -1, -1, -1);
        play(2, 0, -1, -2, -1);

        // abort wins over a simultaneous start in IDLE.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_idle("abort_vs_start");
        @(negedge clk);
        check_idle("abort_vs_start.after");

        // Reset in the middle of step 2; stays idle after release.
        wr(0, 4'h1, 1);
        play(2, 0, -1, -2, 4);
        check("rst.table0", 32'(dut.u_table.pat_q[0]), 32'h0);

        // Out-of-range last step: all 16 entries play.
        for (int i = 0; i < 16; i++) wr(i, (i * 7 + 3) % 16, i % 3);
        play(31, 0, -1, -2, -1);

`ifdef PATTERN_PLAYER_LOOP_EN
        // Looping two zero-dwell steps alternate until aborted.
        wr(0, 4'h5, 0);
        wr(1, 4'hA, 0);
        @(negedge clk);
        last_step = 4'd1; loop = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; loop = 1'b0;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("loop.pat[%0d]", c), 32'(pat_out), (c % 2 == 0) ? 32'h5 : 32'hA);
            check($sformatf("loop.busy[%0d]", c), 32'(busy), 32'h1);
            check($sformatf("loop.done[%0d]", c), 32'(done), 32'h0);
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("loop.abort");
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 16, number of step-table entries (2..256).
REQ-002 SHALL have parameter PAT_W, default 4, width of driven pattern.
REQ-003 SHALL have parameter DWELL_W, default 16, width of per-step dwell count.
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  step-table write strobe.
REQ-008 wr_addr  input  clog2(NUM_STEPS)  table index written.
REQ-009 wr_pat  input  PAT_W  pattern for that step.
REQ-010 wr_dwell  input  DWELL_W  dwell for that step; the step is held for dwell+1 cycles.
REQ-011 last_step  input  clog2(NUM_STEPS)  index of the final step played.
REQ-012 start  input  1  begin playback (level sampled per cycle).
REQ-013 abort  input  1  stop playback.
REQ-014 pat_out  output  PAT_W  driven pattern (the stimulus lines a sequence checker samples).
REQ-015 step_idx  output  clog2(NUM_STEPS)  current step index.
REQ-016 busy  output  1  playback in progress.
REQ-017 done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 SHALL implement FSM states IDLE, PLAY and DONE.
REQ-019 In IDLE, start=1 and abort=0 at edge k SHALL enter PLAY with pat_out=table[0].pat, step_idx=0, busy=1 and counter=table[0].dwell, all valid after edge k.
REQ-020 In PLAY, the counter SHALL decrement each cycle; at counter==0 with step_idx<last_step, the next edge SHALL load step_idx+1, its pattern and its dwell.
REQ-021 At counter==0 with step_idx==last_step, the next edge SHALL enter DONE: pat_out=0, busy=0, done=1 for exactly one cycle; the following edge SHALL return to IDLE.
REQ-022 Step i SHALL drive pat_out for exactly table[i].dwell+1 cycles, with no gap cycles between steps.
REQ-023 start while in PLAY or DONE SHALL be ignored.
REQ-024 abort in any state SHALL force IDLE at the next edge with pat_out=0, busy=0 and done=0; abort wins over a simultaneous start.
REQ-025 wr_en while busy=1 SHALL be dropped; in IDLE or DONE it SHALL write the table at the edge.
REQ-026 A same-cycle write and start SHALL play the pre-write value of entry 0.
REQ-027 If last_step>=NUM_STEPS, it SHALL be treated as NUM_STEPS-1; last_step SHALL be captured at start.
REQ-028 The table SHALL reset to all zeros (pattern 0, dwell 0).

Reset
REQ-029 reset=1 SHALL immediately force IDLE, pat_out=0, step_idx=0, busy=0, done=0, counter=0 and a zero table, including mid-playback.
REQ-030 Playback SHALL NOT resume after reset deasserts; a new start is required.

Configuration
REQ-031 Macro PATTERN_PLAYER_LOOP_EN: when defined, input port loop (1 bit, sampled at start) SHALL be added; with loop=1, completion of last_step SHALL wrap to step 0 with no gap cycle and without entering DONE, until abort.
REQ-032 When the macro is undefined, the loop port SHALL be absent and behaviour is as in REQ-021.

Structure
REQ-033 A shared package pattern_player_pkg SHALL hold the state enum, the step record typedef {pat, dwell} and the default parameter constants.
REQ-034 The table SHALL be a sub-module pattern_player_table: register array with one synchronous write port and one asynchronous read port.

Verification
REQ-035 Write steps {0:pat=0x1,dwell=1; 1:pat=0x6,dwell=0; 2:pat=0xF,dwell=2}, last_step=2, start -> pat_out 1,1,6,F,F,F, then 0 with done=1 for one cycle.
REQ-036 Pulse abort during step 1 of REQ-035 -> pat_out=0 and busy=0 the next cycle, done never asserts.
REQ-037 Assert reset mid-step 2 -> outputs are 0 without a clock edge; after release with no start, pat_out stays 0.
REQ-038 Assert wr_en to entry 0 with pat=0x9 during playback -> write dropped; a replay still shows the old entry-0 pattern.
REQ-039 With last_step=31 and NUM_STEPS=16 -> all 16 steps play, then done.
REQ-040 With PATTERN_PLAYER_LOOP_EN defined, loop=1 and 2 steps of dwell 0 -> pat_out alternates every cycle with no done until abort.
